// File: rtl/csi_packetizer.sv
// CSI-2 style transmit framer: FS/FE short packets and long line packets read from a line FIFO.
// Optional header ECC byte: define CSI_PACKETIZER_ECC_EN (otherwise ECC byte is 8'h00).
module csi_packetizer #(
  parameter logic [7:0] P_DATA_DT = 8'h2B,
  parameter logic [7:0] P_FS_DT   = 8'h00,
  parameter logic [7:0] P_FE_DT   = 8'h01,
  parameter int         P_GAP_CYC = 2
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_fs_req,
  input  logic        I_fe_req,
  input  logic        I_line_req,
  input  logic [15:0] I_line_wc,
  output logic        O_pix_rd,
  input  logic [31:0] I_pix_data,
  output logic        O_hs_valid,
  output logic [31:0] O_hs_data,
  output logic        O_busy,
  output logic        O_req_err,
  output logic        O_frame_active,
  output logic [15:0] O_line_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_PAY, S_GAP} state_t;
  typedef enum logic [1:0] {K_FS, K_FE, K_LINE} kind_t;

  localparam logic [7:0] GAP_LAST = 8'(P_GAP_CYC - 1);

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic [15:0] wc_q, wc_d;
  logic [15:0] rd_rem_q, rd_rem_d;
  logic [15:0] pay_rem_q, pay_rem_d;
  logic [7:0]  gap_q, gap_d;
  logic        pix_rd_q, pix_rd_d;
  logic        hs_valid_q, hs_valid_d;
  logic [31:0] hs_data_q, hs_data_d;
  logic        req_err_q, req_err_d;
  logic        frame_active_q, frame_active_d;
  logic [15:0] line_cnt_q, line_cnt_d;

  logic        any_req;
  logic        line_ok;
  logic [15:0] line_words;
  logic [7:0]  hdr_dt;
  logic [7:0]  ecc_byte;
  logic [31:0] header;

  assign any_req    = I_fs_req | I_fe_req | I_line_req;
  assign line_words = {2'b00, I_line_wc[15:2]};
  assign line_ok    = (I_line_wc[15:2] != 14'd0) && (I_line_wc[1:0] == 2'b00);

  always_comb begin
    case (kind_q)
      K_FS:    hdr_dt = P_FS_DT;
      K_FE:    hdr_dt = P_FE_DT;
      default: hdr_dt = P_DATA_DT;
    endcase
  end

`ifdef CSI_PACKETIZER_ECC_EN
  // Hamming parity over D[23:0] = {WC[15:8], WC[7:0], DT}
  logic [23:0] ecc_d;
  logic [5:0]  ecc6;
  assign ecc_d   = {wc_q[15:8], wc_q[7:0], hdr_dt};
  assign ecc6[0] = ecc_d[0] ^ ecc_d[1] ^ ecc_d[2] ^ ecc_d[4] ^ ecc_d[5] ^ ecc_d[7] ^ ecc_d[10] ^
                   ecc_d[11] ^ ecc_d[13] ^ ecc_d[16] ^ ecc_d[20] ^ ecc_d[21] ^ ecc_d[22] ^ ecc_d[23];
  assign ecc6[1] = ecc_d[0] ^ ecc_d[1] ^ ecc_d[3] ^ ecc_d[4] ^ ecc_d[6] ^ ecc_d[8] ^ ecc_d[10] ^
                   ecc_d[12] ^ ecc_d[14] ^ ecc_d[17] ^ ecc_d[20] ^ ecc_d[21] ^ ecc_d[22] ^ ecc_d[23];
  assign ecc6[2] = ecc_d[0] ^ ecc_d[2] ^ ecc_d[3] ^ ecc_d[5] ^ ecc_d[6] ^ ecc_d[9] ^ ecc_d[11] ^
                   ecc_d[12] ^ ecc_d[15] ^ ecc_d[18] ^ ecc_d[20] ^ ecc_d[21] ^ ecc_d[22];
  assign ecc6[3] = ecc_d[1] ^ ecc_d[2] ^ ecc_d[3] ^ ecc_d[7] ^ ecc_d[8] ^ ecc_d[9] ^ ecc_d[13] ^
                   ecc_d[14] ^ ecc_d[15] ^ ecc_d[19] ^ ecc_d[20] ^ ecc_d[21] ^ ecc_d[23];
  assign ecc6[4] = ecc_d[4] ^ ecc_d[5] ^ ecc_d[6] ^ ecc_d[7] ^ ecc_d[8] ^ ecc_d[9] ^ ecc_d[16] ^
                   ecc_d[17] ^ ecc_d[18] ^ ecc_d[19] ^ ecc_d[20] ^ ecc_d[22] ^ ecc_d[23];
  assign ecc6[5] = ecc_d[10] ^ ecc_d[11] ^ ecc_d[12] ^ ecc_d[13] ^ ecc_d[14] ^ ecc_d[15] ^
                   ecc_d[16] ^ ecc_d[17] ^ ecc_d[18] ^ ecc_d[19] ^ ecc_d[21] ^ ecc_d[22] ^ ecc_d[23];
  assign ecc_byte = {2'b00, ecc6};
`else
  assign ecc_byte = 8'h00;
`endif

  assign header = {hdr_dt, wc_q[7:0], wc_q[15:8], ecc_byte};

  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    wc_d           = wc_q;
    rd_rem_d       = rd_rem_q;
    pay_rem_d      = pay_rem_q;
    gap_d          = gap_q;
    pix_rd_d       = 1'b0;
    hs_valid_d     = 1'b0;
    hs_data_d      = 32'h0;
    req_err_d      = 1'b0;
    frame_active_d = frame_active_q;
    line_cnt_d     = line_cnt_q;

    // FIFO reads run ahead of the packet states; the first read is issued on acceptance.
    if (state_q != S_IDLE && rd_rem_q != 16'd0) begin
      pix_rd_d = 1'b1;
      rd_rem_d = rd_rem_q - 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (I_fs_req) begin
          kind_d    = K_FS;
          wc_d      = 16'h0;
          rd_rem_d  = 16'h0;
          state_d   = S_PRE;
          req_err_d = I_fe_req | I_line_req;
        end else if (I_line_req) begin
          req_err_d = I_fe_req | ~line_ok;
          if (line_ok) begin
            kind_d   = K_LINE;
            wc_d     = I_line_wc;
            pix_rd_d = 1'b1;
            rd_rem_d = line_words - 16'd1;
            state_d  = S_PRE;
          end
        end else if (I_fe_req) begin
          kind_d   = K_FE;
          wc_d     = 16'h0;
          rd_rem_d = 16'h0;
          state_d  = S_PRE;
        end
      end
      S_PRE: begin
        req_err_d  = any_req;
        hs_valid_d = 1'b1;
        hs_data_d  = header;
        pay_rem_d  = {2'b00, wc_q[15:2]};
        state_d    = S_HDR;
        case (kind_q)
          K_FS: begin
            frame_active_d = 1'b1;
            line_cnt_d     = 16'h0;
          end
          K_FE:    frame_active_d = 1'b0;
          default: line_cnt_d = line_cnt_q + 16'd1;
        endcase
      end
      S_HDR: begin
        req_err_d = any_req;
        if (kind_q == K_LINE) begin
          hs_valid_d = 1'b1;
          hs_data_d  = I_pix_data;
          pay_rem_d  = pay_rem_q - 16'd1;
          state_d    = S_PAY;
        end else begin
          gap_d   = GAP_LAST;
          state_d = S_GAP;
        end
      end
      S_PAY: begin
        req_err_d = any_req;
        if (pay_rem_q != 16'd0) begin
          hs_valid_d = 1'b1;
          hs_data_d  = I_pix_data;
          pay_rem_d  = pay_rem_q - 16'd1;
        end else begin
          gap_d   = GAP_LAST;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        req_err_d = any_req;
        if (gap_q == 8'd0) state_d = S_IDLE;
        else               gap_d   = gap_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q        <= S_IDLE;
      kind_q         <= K_FS;
      wc_q           <= 16'h0;
      rd_rem_q       <= 16'h0;
      pay_rem_q      <= 16'h0;
      gap_q          <= 8'h0;
      pix_rd_q       <= 1'b0;
      hs_valid_q     <= 1'b0;
      hs_data_q      <= 32'h0;
      req_err_q      <= 1'b0;
      frame_active_q <= 1'b0;
      line_cnt_q     <= 16'h0;
    end else begin
      state_q        <= state_d;
      kind_q         <= kind_d;
      wc_q           <= wc_d;
      rd_rem_q       <= rd_rem_d;
      pay_rem_q      <= pay_rem_d;
      gap_q          <= gap_d;
      pix_rd_q       <= pix_rd_d;
      hs_valid_q     <= hs_valid_d;
      hs_data_q      <= hs_data_d;
      req_err_q      <= req_err_d;
      frame_active_q <= frame_active_d;
      line_cnt_q     <= line_cnt_d;
    end
  end

  assign O_pix_rd       = pix_rd_q;
  assign O_hs_valid     = hs_valid_q;
  assign O_hs_data      = hs_data_q;
  assign O_busy         = (state_q != S_IDLE);
  assign O_req_err      = req_err_q;
  assign O_frame_active = frame_active_q;
  assign O_line_cnt     = line_cnt_q;

endmodule

// File: tb/tb_csi_packetizer.sv
// Bench for csi_packetizer: vector table, timed corner sequences and a random phase against a packet-level model.
module tb_csi_packetizer;

  localparam int GAP = 2;

  logic        I_clk = 1'b0;
  logic        I_rst_n = 1'b0;
  logic        I_fs_req = 1'b0;
  logic        I_fe_req = 1'b0;
  logic        I_line_req = 1'b0;
  logic [15:0] I_line_wc = 16'h0;
  logic [31:0] I_pix_data = 32'h0;
  logic        O_pix_rd, O_hs_valid, O_busy, O_req_err, O_frame_active;
  logic [31:0] O_hs_data;
  logic [15:0] O_line_cnt;

  csi_packetizer #(.P_DATA_DT(8'h2B), .P_FS_DT(8'h00), .P_FE_DT(8'h01), .P_GAP_CYC(GAP)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_fs_req(I_fs_req), .I_fe_req(I_fe_req),
    .I_line_req(I_line_req), .I_line_wc(I_line_wc), .O_pix_rd(O_pix_rd), .I_pix_data(I_pix_data),
    .O_hs_valid(O_hs_valid), .O_hs_data(O_hs_data), .O_busy(O_busy), .O_req_err(O_req_err),
    .O_frame_active(O_frame_active), .O_line_cnt(O_line_cnt)
  );

  always #5 I_clk = ~I_clk;

  typedef struct {
    logic        fs, fe, line;
    logic [15:0] wc;
    logic        pkt;
    logic [31:0] hdr;
    int          n;
    int          err;
    logic        fa;
    logic [15:0] lc;
  } vec_t;

  int          tests = 0, fails = 0;
  int          err_cnt = 0, busy_cnt = 0, rd_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pix_q[$];
  vec_t        vecs[$];
  logic        m_fa = 1'b0;
  logic [15:0] m_lc = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

`ifdef CSI_PACKETIZER_ECC_EN
  function automatic logic [5:0] ecc_model(input logic [23:0] d);
    logic [5:0] col [24];
    logic [5:0] e;
    col = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19, 6'h1A, 6'h1C, 6'h23, 6'h25,
            6'h26, 6'h29, 6'h2A, 6'h2C, 6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
    e = 6'h0;
    for (int i = 0; i < 24; i++) if (d[i]) e = e ^ col[i];
    return e;
  endfunction
`endif

  function automatic logic [31:0] hdr_fix(input logic [31:0] h);
    logic [31:0] r;
    r = h;
`ifdef CSI_PACKETIZER_ECC_EN
    r[7:0] = {2'b00, ecc_model({h[15:8], h[23:16], h[31:24]})};
`endif
    return r;
  endfunction

  function automatic logic [31:0] hdr_of(input logic [7:0] dt, input logic [15:0] wc);
    return hdr_fix({dt, wc[7:0], wc[15:8], 8'h00});
  endfunction

  // Line FIFO with one cycle read latency
  always @(posedge I_clk) begin
    if (O_pix_rd) begin
      tests++;
      if (pix_q.size() == 0) begin
        fails++;
        $display("FAIL fifo_read: got read with 0 words queued, required a queued word");
        I_pix_data <= 32'hDEADBEEF;
      end else begin
        I_pix_data <= pix_q.pop_front();
      end
    end
  end

  always @(negedge I_clk) begin
    if (I_rst_n) begin
      if (O_req_err) err_cnt++;
      if (O_busy)    busy_cnt++;
      if (O_pix_rd)  rd_cnt++;
      if (O_hs_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL hs_word: got unexpected word %h, required none", O_hs_data);
        end else begin
          chk("hs_word", O_hs_data, exp_q.pop_front());
        end
      end else begin
        chk("hs_idle_data", O_hs_data, 32'h0);
      end
    end
  end

  task automatic pulse_req(input logic fs, input logic fe, input logic line, input logic [15:0] wc);
    I_fs_req = fs; I_fe_req = fe; I_line_req = line; I_line_wc = wc;
    @(negedge I_clk);
    I_fs_req = 1'b0; I_fe_req = 1'b0; I_line_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    @(negedge I_clk);
    while (O_busy && cyc < 3000) begin
      @(negedge I_clk);
      cyc++;
    end
    if (O_busy) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got busy after %0d cycles, required idle", name, cyc);
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int e0, b0, r0;
    logic [31:0] w;
    if (v.pkt) begin
      exp_q.push_back(v.hdr);
      for (int i = 0; i < v.n; i++) begin
        w = $urandom;
        pix_q.push_back(w);
        exp_q.push_back(w);
      end
    end
    e0 = err_cnt; b0 = busy_cnt; r0 = rd_cnt;
    pulse_req(v.fs, v.fe, v.line, v.wc);
    wait_idle(name);
    chk({name, "_words_left"}, 32'(exp_q.size()), 32'h0);
    chk({name, "_err"}, 32'(err_cnt - e0), 32'(v.err));
    chk({name, "_busy_cyc"}, 32'(busy_cnt - b0), v.pkt ? 32'(2 + v.n + GAP) : 32'h0);
    chk({name, "_rd_cyc"}, 32'(rd_cnt - r0), 32'(v.n));
    chk({name, "_frame_active"}, 32'(O_frame_active), 32'(v.fa));
    chk({name, "_line_cnt"}, 32'(O_line_cnt), 32'(v.lc));
  endtask

  // Exact per-cycle timing of one accepted packet, with payload words base+i
  task automatic timed_pkt(input string name, input logic fs, input logic line, input logic [15:0] wc,
                           input logic [31:0] hdr, input logic [31:0] base);
    int n;
    n = line ? int'(wc >> 2) : 0;
    exp_q.push_back(hdr);
    for (int i = 0; i < n; i++) begin
      pix_q.push_back(base + 32'(i));
      exp_q.push_back(base + 32'(i));
    end
    pulse_req(fs, 1'b0, line, wc);
    for (int k = 1; k <= n + GAP + 4; k++) begin
      chk($sformatf("%s_busy_k%0d", name, k), 32'(O_busy), 32'(k <= n + 2 + GAP));
      chk($sformatf("%s_pix_rd_k%0d", name, k), 32'(O_pix_rd), 32'(k <= n));
      chk($sformatf("%s_valid_k%0d", name, k), 32'(O_hs_valid), 32'(k >= 2 && k <= n + 2));
      @(negedge I_clk);
    end
    chk({name, "_words_left"}, 32'(exp_q.size()), 32'h0);
  endtask

  task automatic model_req(input logic fs, input logic fe, input logic line, input logic [15:0] wc,
                           output vec_t v);
    v = '{fs, fe, line, wc, 1'b0, 32'h0, 0, 0, 1'b0, 16'h0};
    if (fs) begin
      v.pkt = 1'b1; v.hdr = hdr_of(8'h00, 16'h0); v.err = (fe || line) ? 1 : 0;
      m_fa = 1'b1; m_lc = 16'h0;
    end else if (line) begin
      if (wc < 4 || wc % 4 != 0) begin
        v.err = 1;
      end else begin
        v.pkt = 1'b1; v.n = int'(wc) / 4; v.hdr = hdr_of(8'h2B, wc); v.err = fe ? 1 : 0;
        m_lc = m_lc + 16'd1;
      end
    end else if (fe) begin
      v.pkt = 1'b1; v.hdr = hdr_of(8'h01, 16'h0);
      m_fa = 1'b0;
    end
    v.fa = m_fa;
    v.lc = m_lc;
  endtask

  initial begin
    vec_t v;
    int e0, b0;
    logic fs, fe, line;
    logic [15:0] wc;

    // fs fe line wc | pkt hdr(ECC byte 0) n err | frame_active line_cnt
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'd0,   1'b1, 32'h00000000, 0,  0, 1'b1, 16'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 16'd16,  1'b1, 32'h2B100000, 4,  0, 1'b1, 16'd1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 16'd6,   1'b0, 32'h0,        0,  1, 1'b1, 16'd1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 16'd2,   1'b0, 32'h0,        0,  1, 1'b1, 16'd1});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 16'd0,   1'b1, 32'h00000000, 0,  1, 1'b1, 16'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'd0,   1'b1, 32'h01000000, 0,  0, 1'b0, 16'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 16'h104, 1'b1, 32'h2B040100, 65, 0, 1'b0, 16'd1});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 16'd8,   1'b1, 32'h00000000, 0,  1, 1'b1, 16'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 16'd8,   1'b1, 32'h2B080000, 2,  1, 1'b1, 16'd1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 16'd0,   1'b0, 32'h0,        0,  1, 1'b1, 16'd1});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 16'd5,   1'b0, 32'h0,        0,  1, 1'b1, 16'd1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'd0,   1'b1, 32'h01000000, 0,  0, 1'b0, 16'd1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'd0,   1'b1, 32'h01000000, 0,  0, 1'b0, 16'd1});

    repeat (2) @(negedge I_clk);
    chk("rst_busy", 32'(O_busy), 32'h0);
    chk("rst_valid", 32'(O_hs_valid), 32'h0);
    chk("rst_data", O_hs_data, 32'h0);
    chk("rst_pix_rd", 32'(O_pix_rd), 32'h0);
    chk("rst_req_err", 32'(O_req_err), 32'h0);
    chk("rst_frame_active", 32'(O_frame_active), 32'h0);
    chk("rst_line_cnt", 32'(O_line_cnt), 32'h0);
    I_rst_n = 1'b1;
    @(negedge I_clk);

    timed_pkt("fs_first", 1'b1, 1'b0, 16'd0, hdr_of(8'h00, 16'h0), 32'h0);
    chk("fs_first_frame_active", 32'(O_frame_active), 32'h1);
    chk("fs_first_line_cnt", 32'(O_line_cnt), 32'h0);
    timed_pkt("line16", 1'b0, 1'b1, 16'd16, hdr_fix(32'h2B100000), 32'hA0);
    chk("line16_line_cnt", 32'(O_line_cnt), 32'h1);

    foreach (vecs[i]) begin
      v = vecs[i];
      v.hdr = hdr_fix(v.hdr);
      run_vec($sformatf("vec%0d", i), v);
      m_fa = v.fa;
      m_lc = v.lc;
    end

    // Second request during payload is rejected; next request right after the gap is accepted
    exp_q.push_back(hdr_of(8'h2B, 16'd8));
    for (int i = 0; i < 2; i++) begin
      pix_q.push_back(32'hC0 + 32'(i));
      exp_q.push_back(32'hC0 + 32'(i));
    end
    e0 = err_cnt; b0 = busy_cnt;
    pulse_req(1'b0, 1'b0, 1'b1, 16'd8);
    repeat (2) @(negedge I_clk);
    pulse_req(1'b0, 1'b0, 1'b1, 16'd8);
    wait_idle("busy_req");
    m_lc = m_lc + 16'd1;
    chk("busy_req_err", 32'(err_cnt - e0), 32'h1);
    chk("busy_req_busy_cyc", 32'(busy_cnt - b0), 32'(4 + GAP));
    chk("busy_req_words_left", 32'(exp_q.size()), 32'h0);
    chk("busy_req_line_cnt", 32'(O_line_cnt), 32'(m_lc));
    model_req(1'b1, 1'b0, 1'b0, 16'd0, v);
    run_vec("after_gap_fs", v);

    for (int it = 0; it < 40; it++) begin
      fs   = ($urandom_range(0, 4) == 0);
      fe   = ($urandom_range(0, 4) == 0);
      line = ($urandom_range(0, 1) == 1);
      if (!fs && !fe && !line) line = 1'b1;
      wc = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom_range(1, 24) * 4);
      model_req(fs, fe, line, wc, v);
      run_vec($sformatf("rnd%0d", it), v);
    end

    // Reset in the middle of a 16-word payload
    exp_q.push_back(hdr_of(8'h2B, 16'd64));
    for (int i = 0; i < 16; i++) begin
      pix_q.push_back(32'hE0 + 32'(i));
      exp_q.push_back(32'hE0 + 32'(i));
    end
    pulse_req(1'b0, 1'b0, 1'b1, 16'd64);
    repeat (5) @(negedge I_clk);
    I_rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(O_hs_valid), 32'h0);
    chk("midrst_pix_rd", 32'(O_pix_rd), 32'h0);
    chk("midrst_busy", 32'(O_busy), 32'h0);
    chk("midrst_data", O_hs_data, 32'h0);
    chk("midrst_line_cnt", 32'(O_line_cnt), 32'h0);
    exp_q.delete();
    pix_q.delete();
    repeat (3) @(negedge I_clk);
    I_rst_n = 1'b1;
    m_fa = 1'b0;
    m_lc = 16'h0;
    @(negedge I_clk);
    model_req(1'b1, 1'b0, 1'b0, 16'd0, v);
    run_vec("post_rst_fs", v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/csi_packetizer.md
Name: csi_packetizer

Overview:
- Transmit-side CSI-2 style packet framer; produces the 32-bit word stream that the team's CSI receive path (header detect on valid rising edge) consumes.
- Builds short packets for frame start (FS) and frame end (FE), and long line packets from a pre-buffered line FIFO.
- Sits between the line buffer / test-pattern source and the HS lane serializer, or between that source and a loopback into the receive path.

Parameters:
- P_DATA_DT, 8'h2B, data type byte for long line packets (RAW10).
- P_FS_DT, 8'h00, frame start short packet data type.
- P_FE_DT, 8'h01, frame end short packet data type.
- P_GAP_CYC, 2, idle cycles forced after every packet (O_hs_valid=0); minimum 1.

Ports:
- I_clk  in  1  clock
- I_rst_n  in  1  reset, asynchronous, active-low
- I_fs_req  in  1  pulse: send FS short packet
- I_fe_req  in  1  pulse: send FE short packet
- I_line_req  in  1  pulse: send one line long packet
- I_line_wc  in  16  line byte count, sampled with I_line_req
- O_pix_rd  out  1  read enable to line FIFO (FIFO read latency 1 cycle)
- I_pix_data  in  32  FIFO read data, valid one cycle after O_pix_rd
- O_hs_valid  out  1  packet word valid (contiguous within a packet)
- O_hs_data  out  32  packet word
- O_busy  out  1  packet in progress; requests ignored while high
- O_req_err  out  1  one-cycle pulse: request rejected
- O_frame_active  out  1  high between sent FS and sent FE
- O_line_cnt  out  16  lines sent since last FS

Behaviour:
- Reset (async): state IDLE; all outputs 0; gap counter 0.
- Header word layout: [31:24]=DT, [23:16]=WC[7:0], [15:8]=WC[15:8], [7:0]=ECC.
  - Short packets: WC=0.
  - Long packets: WC=I_line_wc.
- Payload words: N = I_line_wc>>2.
- States: IDLE, PRE, HDR, PAY, GAP.
- IDLE:
  - Samples requests.
  - Priority if simultaneous: FS > LINE > FE; lower-priority requests in the same cycle are dropped and O_req_err pulses.
  - Line request with I_line_wc<4 or I_line_wc[1:0]!=0: rejected, O_req_err pulse, no packet, stays IDLE.
- Accepted request at edge T:
  - O_busy=1 from T+1 through the last GAP cycle.
  - PRE at T+1. For a line packet, O_pix_rd=1 for cycles T+1..T+N.
  - HDR: header word at T+2, O_hs_valid=1.
  - PAY (line only): FIFO words registered to O_hs_data at T+3..T+N+2, in FIFO order, no bubbles.
  - GAP: O_hs_valid=0 and O_hs_data=0 for P_GAP_CYC cycles, then IDLE with O_busy=0.
  - The next request is accepted in the first IDLE cycle.
- Latency: request to header = 2 cycles. Packet length = 1 word (short) or 1+N words (long).
- Requests while O_busy=1: ignored, O_req_err pulses one cycle per offending request cycle.
- O_frame_active:
  - Set in the FS HDR cycle; cleared in the FE HDR cycle.
  - FS while active: packet still sent, O_line_cnt reset.
  - FE while inactive: packet still sent, no error.
- O_line_cnt:
  - Cleared in the FS HDR cycle.
  - +1 in each line HDR cycle; wraps 16'hFFFF->0.
  - Line packets outside a frame are still sent and counted.
- Reset mid-packet: immediate IDLE, O_hs_valid=0, O_pix_rd=0. The FIFO flush is the upstream's responsibility.
- O_hs_data is 0 whenever O_hs_valid=0.

Optional Feature:
- Macro CSI_PACKETIZER_ECC_EN.
- Defined: header [7:0] = {2'b00, ECC6}.
  - ECC6 is the MIPI CSI-2 header Hamming ECC over D[23:0] = {WC[15:8], WC[7:0], DT}.
  - Computed combinationally from the latched request; no extra latency.
- Undefined: header [7:0] = 8'h00.

Test Plan:
- FS request after reset -> busy at T+1; header 32'h00000000 valid one cycle at T+2; 2 idle cycles; O_frame_active=1, O_line_cnt=0.
- FS, then line req wc=16 with FIFO words 0xA0..0xA3 -> header 32'h2B100000 (ECC off), then 0xA0,0xA1,0xA2,0xA3 contiguous; O_pix_rd high 4 cycles; O_line_cnt=1.
- Line req wc=6, then wc=2 -> both rejected: O_req_err pulse each, no O_hs_valid, O_busy stays 0.
- Line req wc=8 and second line req issued during payload -> second request gets an O_req_err pulse; only one 3-word packet is sent; a new request after the GAP is accepted.
- FS and FE simultaneously in IDLE -> FS sent, O_req_err pulse; later FE -> header 32'h01000000, O_frame_active=0.
- Reset asserted mid-payload of a wc=64 line -> O_hs_valid, O_pix_rd, O_busy are 0 immediately; after release, FS is accepted normally. With ECC_EN, line header ECC matches the bench model for DT=2B, WC=0x0010.
